// File: rtl/ahb_matrix_pkg.sv
// Shared bus-matrix encodings: AHB transfer/burst/response codes and the
// input-stage state type.
package ahb_matrix_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

endpackage

// File: rtl/ahb_matrix_input_stage_if.sv
// Input-stage bus bundle: master-facing *S side and matrix-facing *I side.
// slave = the input stage's view, master = the view of whatever drives it.
interface ahb_matrix_input_stage_if #(
  parameter int ADDR_W = 32,
  parameter int PROT_W = 4
);
  logic              HSELS;
  logic [ADDR_W-1:0] HADDRS;
  logic [1:0]        HTRANSS;
  logic              HWRITES;
  logic [2:0]        HSIZES;
  logic [2:0]        HBURSTS;
  logic [PROT_W-1:0] HPROTS;
  logic              HMASTLOCKS;
  logic              HREADYS;
  logic              HREADYOUTS;
  logic              HRESPS;

  logic              HSELI;
  logic [ADDR_W-1:0] HADDRI;
  logic [1:0]        HTRANSI;
  logic              HWRITEI;
  logic [2:0]        HSIZEI;
  logic [2:0]        HBURSTI;
  logic [PROT_W-1:0] HPROTI;
  logic              HMASTLOCKI;
  logic              HREADYI;

  logic              accept_dec;
  logic              readyout_dec;
  logic              resp_dec;

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
    input  accept_dec, readyout_dec, resp_dec,
    output HREADYOUTS, HRESPS,
    output HSELI, HADDRI, HTRANSI, HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI, HREADYI
  );

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
    output accept_dec, readyout_dec, resp_dec,
    input  HREADYOUTS, HRESPS,
    input  HSELI, HADDRI, HTRANSI, HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI, HREADYI
  );
endinterface

// File: rtl/ahb_matrix_hold_reg.sv
// Load-enabled holding register for one refused address phase.
module ahb_matrix_hold_reg #(
  parameter int ADDR_W = 32,
  parameter int PROT_W = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              load,
  input  logic              sel_d,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [1:0]        trans_d,
  input  logic              write_d,
  input  logic [2:0]        size_d,
  input  logic [2:0]        burst_d,
  input  logic [PROT_W-1:0] prot_d,
  input  logic              lock_d,
  output logic              sel_q,
  output logic [ADDR_W-1:0] addr_q,
  output logic [1:0]        trans_q,
  output logic              write_q,
  output logic [2:0]        size_q,
  output logic [2:0]        burst_q,
  output logic [PROT_W-1:0] prot_q,
  output logic              lock_q
);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_q   <= 1'b0;
      addr_q  <= '0;
      trans_q <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      burst_q <= '0;
      prot_q  <= '0;
      lock_q  <= 1'b0;
    end else if (load) begin
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      trans_q <= trans_d;
      write_q <= write_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      prot_q  <= prot_d;
      lock_q  <= lock_d;
    end
  end

endmodule

// File: rtl/ahb_matrix_input_stage.sv
// Bus-matrix input port front end: holds a refused address phase, stalls the
// master while it is replayed, and returns the routed slave's ready/response.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | nothing held; address phase passes straight through
//   ST_PEND | one refused transfer held and replayed; master stalled
module ahb_matrix_input_stage
  import ahb_matrix_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int PROT_W = 4
) (
  input logic                     HCLK,
  input logic                     HRESET,
  ahb_matrix_input_stage_if.slave bus
);

  state_t            state, state_nxt;
  logic              dphase, dphase_nxt;
  logic              hold_load;
  logic              new_tran;

  logic              hold_sel;
  logic [ADDR_W-1:0] hold_addr;
  logic [1:0]        hold_trans;
  logic              hold_write;
  logic [2:0]        hold_size;
  logic [2:0]        hold_burst;
  logic [PROT_W-1:0] hold_prot;
  logic              hold_lock;

  assign new_tran = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state  <= ST_IDLE;
      dphase <= 1'b0;
    end else begin
      state  <= state_nxt;
      dphase <= dphase_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    dphase_nxt = dphase;
    hold_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (new_tran) begin
          if (bus.accept_dec) begin
            dphase_nxt = 1'b1;
          end else begin
            state_nxt  = ST_PEND;
            hold_load  = 1'b1;
            dphase_nxt = 1'b0;
          end
        end else if (bus.HREADYS) begin
          dphase_nxt = 1'b0;
        end
      end
      ST_PEND: begin
        if (bus.accept_dec) begin
          state_nxt  = ST_IDLE;
          dphase_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  ahb_matrix_hold_reg #(.ADDR_W(ADDR_W), .PROT_W(PROT_W)) u_hold (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .load    (hold_load),
    .sel_d   (bus.HSELS),
    .addr_d  (bus.HADDRS),
    .trans_d (bus.HTRANSS),
    .write_d (bus.HWRITES),
    .size_d  (bus.HSIZES),
    .burst_d (bus.HBURSTS),
    .prot_d  (bus.HPROTS),
    .lock_d  (bus.HMASTLOCKS),
    .sel_q   (hold_sel),
    .addr_q  (hold_addr),
    .trans_q (hold_trans),
    .write_q (hold_write),
    .size_q  (hold_size),
    .burst_q (hold_burst),
    .prot_q  (hold_prot),
    .lock_q  (hold_lock)
  );

  // Held phase is replayed with HREADYI forced high: the master-side bus is
  // stalled by us, but the output stages must still see a valid request.
  assign bus.HSELI      = (state == ST_PEND) ? hold_sel   : bus.HSELS;
  assign bus.HADDRI     = (state == ST_PEND) ? hold_addr  : bus.HADDRS;
  assign bus.HTRANSI    = (state == ST_PEND) ? hold_trans : bus.HTRANSS;
  assign bus.HWRITEI    = (state == ST_PEND) ? hold_write : bus.HWRITES;
  assign bus.HSIZEI     = (state == ST_PEND) ? hold_size  : bus.HSIZES;
  assign bus.HBURSTI    = (state == ST_PEND) ? hold_burst : bus.HBURSTS;
  assign bus.HPROTI     = (state == ST_PEND) ? hold_prot  : bus.HPROTS;
  assign bus.HMASTLOCKI = (state == ST_PEND) ? hold_lock  : bus.HMASTLOCKS;
  assign bus.HREADYI    = (state == ST_PEND) ? 1'b1       : bus.HREADYS;

  assign bus.HREADYOUTS = (state == ST_PEND) ? 1'b0 :
                          (dphase ? bus.readyout_dec : 1'b1);
  assign bus.HRESPS     = (state == ST_PEND) ? HRESP_OKAY :
                          (dphase ? bus.resp_dec : HRESP_OKAY);

  ap_no_stray_accept: assert property (@(posedge HCLK) disable iff (HRESET)
    !((state == ST_IDLE) && !new_tran && bus.accept_dec));

endmodule
